instr_sequencer: RTL

- Multi-cycle control FSM that sequences the 19-bit-instruction datapath.
- Fetches the instruction word from instruction memory and holds it in an instruction register (IR). The IR feeds the field decoder (opcode[18:14], rd[13:10], rs1[9:6], rs2[5:2], imm[9:0], addr[13:0]).
- Steps the ALU, register file and data memory through FETCH/DECODE/EXEC/MEM/WB.
- Owns the PC and the zero flag.
- Sits between the memories and the decoder/ALU/register file.

---
 rtl/seq_pkg.sv | 60 ++++++
 rtl/instr_sequencer_if.sv | 49 ++++
 rtl/seq_wait_timer.sv | 42 ++++
 rtl/instr_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared constants and types for the instruction sequencer:
//               opcode map, FSM state encoding, register-file write-source
//               select codes, trap cause codes and datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  localparam int PC_W    = 14;
  localparam int INSTR_W = 19;
  localparam int OPC_W   = 5;

  // Opcode map (instruction bits [18:14])
  localparam logic [OPC_W-1:0] OP_NOP    = 5'h00;
  localparam logic [OPC_W-1:0] OP_ALU_LO = 5'h01;
  localparam logic [OPC_W-1:0] OP_ALU_HI = 5'h0F;
  localparam logic [OPC_W-1:0] OP_LDI    = 5'h10;
  localparam logic [OPC_W-1:0] OP_LD     = 5'h11;
  localparam logic [OPC_W-1:0] OP_ST     = 5'h12;
  localparam logic [OPC_W-1:0] OP_JMP    = 5'h13;
  localparam logic [OPC_W-1:0] OP_BEQ    = 5'h14;
  localparam logic [OPC_W-1:0] OP_BNE    = 5'h15;
  localparam logic [OPC_W-1:0] OP_HALT   = 5'h1F;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5,
    TRAP   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_IMM  = 2'd1,
    WSEL_DMEM = 2'd2
  } wsel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } cause_e;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  // 5'h00..5'h15 are contiguous legal codes; HALT is the only one above.
  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    return (op <= OP_BNE) || (op == OP_HALT);
  endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_if
// Description : Bundle of every sequencer-facing signal: instruction memory
//               fetch handshake, data memory request handshake, ALU and
//               register-file strobes, architectural state (ir, pc, z_flag),
//               status (halted, trap, trap_cause) and performance counters.
//               master = sequencer side, slave = memories/datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_sequencer_if;
  import seq_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    pc;
  logic               alu_en;
  logic               alu_zero;
  logic               rf_we;
  logic [1:0]         rf_wsel;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ready;
  logic               z_flag;
  logic               halted;
  logic               trap;
  logic [1:0]         trap_cause;
  logic [31:0]        perf_cycles;
  logic [31:0]        perf_retired;

  modport master (
    output imem_req, imem_addr, ir, pc, alu_en, rf_we, rf_wsel,
           dmem_req, dmem_we, z_flag, halted, trap, trap_cause,
           perf_cycles, perf_retired,
    input  imem_rdata, imem_valid, alu_zero, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir, pc, alu_en, rf_we, rf_wsel,
           dmem_req, dmem_we, z_flag, halted, trap, trap_cause,
           perf_cycles, perf_retired,
    output imem_rdata, imem_valid, alu_zero, dmem_ready
  );

endinterface : instr_sequencer_if
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_wait_timer
// Description : Memory wait-cycle counter. Counts enabled cycles since the
//               last clear; timeout flags the enabled cycle on which the
//               count reaches MEM_TIMEOUT, so the owner can leave its wait
//               state on that same edge.
// Ports       : clk, rst (sync, active-high)
//               clr     - restart the count (higher priority than en)
//               en      - this cycle is a wait cycle
//               timeout - this wait cycle is the MEM_TIMEOUT-th one
// Revision    : 1.0 - initial release
// ============================================================================
module seq_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = 8'd0;
    else if (en) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  // Deliberately independent of clr: the owner derives clr from its
  // next-state, which itself depends on timeout.
  assign timeout = en && (count_q == 8'(MEM_TIMEOUT - 1));

endmodule : seq_wait_timer
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle control FSM for the 19-bit instruction datapath.
//               Fetches into the IR, owns pc and the zero flag, and steps the
//               ALU / register file / data memory through
//               FETCH -> DECODE -> EXEC -> (MEM) -> (WB). HALTED and TRAP are
//               terminal until rst.
// Ports       : clk, rst (sync, active-high)
//               bus (instr_sequencer_if.master): imem_*, dmem_*, ir, pc,
//               alu_en/alu_zero, rf_we/rf_wsel, z_flag, halted, trap,
//               trap_cause, perf_cycles, perf_retired
// Config      : INSTR_SEQUENCER_PERF_EN - enables the perf_cycles and
//               perf_retired counters; when undefined both read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 14'h0000,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  instr_sequencer_if.master   bus
);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               z_flag_q, z_flag_d;
  logic [1:0]         cause_q, cause_d;

  logic [OPC_W-1:0]   opcode;
  logic               timeout;
  logic               wait_en;
  logic               wait_clr;

  logic               imem_req;
  logic               alu_en;
  logic               rf_we;
  logic [1:0]         rf_wsel;
  logic               dmem_req;
  logic               dmem_we;

  assign opcode = ir_q[INSTR_W-1 -: OPC_W];

  // Wait cycles are the requesting states without their completion.
  assign wait_en  = ((state_q == FETCH) && !bus.imem_valid) ||
                    ((state_q == MEM)   && !bus.dmem_ready);
  assign wait_clr = (state_d != state_q);

  seq_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .en      (wait_en),
    .timeout (timeout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      z_flag_q <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_flag_q <= z_flag_d;
      cause_q  <= cause_d;
    end
  end

  // Next-state and architectural-state update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_flag_d = z_flag_q;
    cause_d  = cause_q;
    case (state_q)
      FETCH: begin
        if (bus.imem_valid) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + 14'd1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      DECODE: begin
        if (!is_legal_op(opcode)) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (opcode == OP_HALT) begin
          state_d = HALTED;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        if (is_alu_op(opcode) || (opcode == OP_LDI)) begin
          state_d = WB;
        end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
          state_d = MEM;
        end else if ((opcode == OP_JMP) ||
                     ((opcode == OP_BEQ) &&  z_flag_q) ||
                     ((opcode == OP_BNE) && !z_flag_q)) begin
          pc_d = ir_q[PC_W-1:0];
        end
      end
      MEM: begin
        if (bus.dmem_ready) begin
          state_d = (opcode == OP_LD) ? WB : FETCH;
        end else if (timeout) begin
          state_d = TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      WB: begin
        // alu_zero belongs to the ALU strobe issued in the preceding EXEC.
        if (is_alu_op(opcode)) z_flag_d = bus.alu_zero;
        state_d = FETCH;
      end
      HALTED, TRAP: state_d = state_q;
      default:      state_d = FETCH;
    endcase
  end

  // Outputs: each strobe belongs to exactly one state, which keeps them
  // mutually exclusive by construction.
  always_comb begin
    imem_req = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    rf_wsel  = WSEL_ALU;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      FETCH: imem_req = 1'b1;
      EXEC:  alu_en   = is_alu_op(opcode);
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_ST);
      end
      WB: begin
        rf_we = 1'b1;
        if (opcode == OP_LDI)     rf_wsel = WSEL_IMM;
        else if (opcode == OP_LD) rf_wsel = WSEL_DMEM;
        else                      rf_wsel = WSEL_ALU;
      end
      default: ;
    endcase
  end

  assign bus.imem_req   = imem_req;
  assign bus.imem_addr  = pc_q;
  assign bus.ir         = ir_q;
  assign bus.pc         = pc_q;
  assign bus.alu_en     = alu_en;
  assign bus.rf_we      = rf_we;
  assign bus.rf_wsel    = rf_wsel;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.z_flag     = z_flag_q;
  assign bus.halted     = (state_q == HALTED);
  assign bus.trap       = (state_q == TRAP);
  assign bus.trap_cause = cause_q;

`ifdef INSTR_SEQUENCER_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_retired_q, perf_retired_d;
  logic        retire;

  // An instruction completes when control returns to FETCH from a
  // post-decode state.
  assign retire = (state_d == FETCH) &&
                  ((state_q == EXEC) || (state_q == MEM) || (state_q == WB));

  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_retired_d = perf_retired_q;
    if ((state_q != HALTED) && (state_q != TRAP)) perf_cycles_d = perf_cycles_q + 32'd1;
    if (retire) perf_retired_d = perf_retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_retired_q <= perf_retired_d;
    end
  end

  assign bus.perf_cycles  = perf_cycles_q;
  assign bus.perf_retired = perf_retired_q;
`else
  assign bus.perf_cycles  = 32'd0;
  assign bus.perf_retired = 32'd0;
`endif

endmodule : instr_sequencer
`default_nettype wire
